// File: rtl/mix_seq_pkg.sv
// Shared types and sizing for the voice mix sequencer.
// Optional feature macro: VOICE_MIX_MUTE_EN (per-voice mute mask).
package mix_seq_pkg;

  localparam int unsigned DATA_BITS = 12;
  localparam int unsigned VOICES    = 4;
  localparam int unsigned IDX_BITS  = $clog2(VOICES);
  localparam int unsigned ACC_BITS  = DATA_BITS + IDX_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/voice_mix_sequencer_if.sv
// Voice bank / DAC side signals of the mix sequencer.
// Optional feature macro: VOICE_MIX_MUTE_EN adds mute_mask.
interface voice_mix_sequencer_if;
  import mix_seq_pkg::*;

  logic                          sample_tick;
  logic [VOICES*DATA_BITS-1:0]   voice_in;
  logic [DATA_BITS-1:0]          dout;
  logic                          dout_valid;
  logic                          busy;
  logic                          overrun;
`ifdef VOICE_MIX_MUTE_EN
  logic [VOICES-1:0]             mute_mask;

  modport master (output sample_tick, voice_in, mute_mask,
                  input  dout, dout_valid, busy, overrun);
  modport slave  (input  sample_tick, voice_in, mute_mask,
                  output dout, dout_valid, busy, overrun);
`else
  modport master (output sample_tick, voice_in,
                  input  dout, dout_valid, busy, overrun);
  modport slave  (input  sample_tick, voice_in,
                  output dout, dout_valid, busy, overrun);
`endif

endinterface

// File: rtl/mix_accumulator.sv
// Shared clear/add accumulator; wide enough that VOICES full-scale adds never overflow.
module mix_accumulator
  import mix_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic                 i_add_en,
  input  logic [DATA_BITS-1:0] i_addend,
  output logic [DATA_BITS-1:0] o_avg_c
);

  logic [ACC_BITS-1:0] r_acc;

  // Running sum: clear has priority over add
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_acc <= '0;
    end else if (i_add_en) begin
      r_acc <= r_acc + ACC_BITS'(i_addend);
    end
  end

  // Truncated average: drop the log2(VOICES) low bits
  assign o_avg_c = r_acc[ACC_BITS-1:IDX_BITS];

endmodule

// File: rtl/voice_mix_sequencer.sv
// Time-multiplexed N-voice mixer: snapshot on tick, one voice added per clock, emit average.
// Optional feature macro: VOICE_MIX_MUTE_EN (mute_mask latched with the snapshot).
module voice_mix_sequencer
  import mix_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  voice_mix_sequencer_if.slave  bus
);

  state_t                      r_state, w_state_nxt;
  logic [IDX_BITS-1:0]         r_idx;
  logic [VOICES*DATA_BITS-1:0] r_snap;
  logic [DATA_BITS-1:0]        r_dout;
  logic                        r_dout_valid, r_busy, r_overrun;
  logic                        w_dout_valid_nxt, w_busy_nxt, w_overrun_nxt;
  logic                        w_start, w_add_en;
  logic [DATA_BITS-1:0]        w_sel, w_avg;
`ifdef VOICE_MIX_MUTE_EN
  logic [VOICES-1:0]           r_mute;
`endif

  // State and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_dout_valid <= w_dout_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_overrun    <= w_overrun_nxt;
    end
  end

  // Next-state and control decode
  always_comb begin
    w_state_nxt      = r_state;
    w_dout_valid_nxt = 1'b0;
    w_overrun_nxt    = 1'b0;
    w_start          = 1'b0;
    w_add_en         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.sample_tick) begin
          w_start     = 1'b1;
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        w_add_en      = 1'b1;
        w_overrun_nxt = bus.sample_tick;
        if (r_idx == IDX_BITS'(VOICES - 1)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_dout_valid_nxt = 1'b1;
        w_overrun_nxt    = bus.sample_tick;
        w_state_nxt      = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // Snapshot, voice index and output hold register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_snap <= '0;
      r_dout <= '0;
`ifdef VOICE_MIX_MUTE_EN
      r_mute <= '0;
`endif
    end else begin
      if (w_start) begin
        r_snap <= bus.voice_in;
        r_idx  <= '0;
`ifdef VOICE_MIX_MUTE_EN
        r_mute <= bus.mute_mask;
`endif
      end else if (w_add_en) begin
        r_idx <= r_idx + IDX_BITS'(1);
      end
      if (w_dout_valid_nxt) begin
        r_dout <= w_avg;
      end
    end
  end

  // Select the current voice from the snapshot; muted voices still take their cycle
  always_comb begin
    w_sel = r_snap[r_idx*DATA_BITS +: DATA_BITS];
`ifdef VOICE_MIX_MUTE_EN
    if (r_mute[r_idx]) begin
      w_sel = '0;
    end
`endif
  end

  mix_accumulator u_acc (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_start),
    .i_add_en (w_add_en),
    .i_addend (w_sel),
    .o_avg_c  (w_avg)
  );

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.busy       = r_busy;
  assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_voice_mix_sequencer.sv
// Directed self-checking bench for voice_mix_sequencer (VOICES=4, DATA_BITS=12).
module tb_voice_mix_sequencer;
  import mix_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  localparam logic [47:0] V_RAMP  = {12'h400, 12'h300, 12'h200, 12'h100};
  localparam logic [47:0] V_SMALL = {12'h040, 12'h030, 12'h020, 12'h010};
  localparam logic [47:0] V_FULL  = {4{12'hFFF}};

  always #5 clk = ~clk;

  voice_mix_sequencer_if bus();

  voice_mix_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a tick for exactly one edge (E0); returns just after E0
  task automatic pulse_tick();
    bus.sample_tick = 1'b1;
    step();
    bus.sample_tick = 1'b0;
  endtask

  // Edges after E0 until dout_valid is seen, or -1 if not within 20
  task automatic wait_valid(output int lat);
    int k;
    k   = 0;
    lat = -1;
    while (lat < 0 && k < 20) begin
      step();
      k++;
      if (bus.dout_valid === 1'b1) lat = k;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.sample_tick = 1'b1;
    bus.voice_in = V_FULL;
    step();
    bus.sample_tick = 1'b0;
    step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.dout !== 12'h000) begin errors++; $display("FAIL reset_dout got %h want 000", bus.dout); end
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.dout_valid); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int lat;
    bus.voice_in = V_RAMP;
    pulse_tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start got %b want 1", bus.busy); end
    wait_valid(lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency got %0d want 5", lat); end
    checks++; if (bus.dout !== 12'h280) begin errors++; $display("FAIL basic_dout got %h want 280", bus.dout); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_valid got %b want 0", bus.busy); end
    step();
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_width got %b want 0", bus.dout_valid); end
    checks++; if (bus.dout !== 12'h280) begin errors++; $display("FAIL basic_dout_hold got %h want 280", bus.dout); end
  endtask

  task automatic test_extremes();
    int lat;
    bus.voice_in = V_FULL;
    pulse_tick();
    wait_valid(lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL full_latency got %0d want 5", lat); end
    checks++; if (bus.dout !== 12'hFFF) begin errors++; $display("FAIL full_dout got %h want fff", bus.dout); end
    step();
    bus.voice_in = '0;
    pulse_tick();
    wait_valid(lat);
    checks++; if (bus.dout !== 12'h000) begin errors++; $display("FAIL zero_dout got %h want 000", bus.dout); end
    step();
  endtask

  task automatic test_overrun();
    int nvalid;
    int novr;
    bus.voice_in = V_RAMP;
    pulse_tick();
    step();
    bus.sample_tick = 1'b1;
    bus.voice_in = V_FULL;
    step();
    bus.sample_tick = 1'b0;
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_pulse got %b want 1", bus.overrun); end
    nvalid = 0;
    novr   = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.overrun === 1'b1) novr++;
      if (bus.dout_valid === 1'b1) begin
        nvalid++;
        checks++; if (bus.dout !== 12'h280) begin errors++; $display("FAIL overrun_dout got %h want 280", bus.dout); end
      end
    end
    checks++; if (novr !== 0) begin errors++; $display("FAIL overrun_width got %0d extra cycles want 0", novr); end
    checks++; if (nvalid !== 1) begin errors++; $display("FAIL overrun_valid_count got %0d want 1", nvalid); end
  endtask

  task automatic test_snapshot();
    int lat;
    bus.voice_in = V_SMALL;
    pulse_tick();
    bus.voice_in = V_FULL;
    wait_valid(lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL snap_latency got %0d want 5", lat); end
    checks++; if (bus.dout !== 12'h028) begin errors++; $display("FAIL snap_dout got %h want 028", bus.dout); end
    step();
  endtask

  task automatic test_reset_midmix();
    int lat;
    int nvalid;
    bus.voice_in = V_RAMP;
    pulse_tick();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    checks++; if (bus.dout !== 12'h000) begin errors++; $display("FAIL midrst_dout got %h want 000", bus.dout); end
    nvalid = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.dout_valid === 1'b1) nvalid++;
      step();
    end
    checks++; if (nvalid !== 0) begin errors++; $display("FAIL midrst_valid got %0d want 0", nvalid); end
    bus.voice_in = V_RAMP;
    pulse_tick();
    wait_valid(lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL midrst_relat got %0d want 5", lat); end
    checks++; if (bus.dout !== 12'h280) begin errors++; $display("FAIL midrst_redout got %h want 280", bus.dout); end
    step();
  endtask

`ifdef VOICE_MIX_MUTE_EN
  task automatic test_mute();
    int lat;
    bus.voice_in  = V_RAMP;
    bus.mute_mask = 4'b1010;
    pulse_tick();
    bus.mute_mask = 4'b0000;
    wait_valid(lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL mute_latency got %0d want 5", lat); end
    checks++; if (bus.dout !== 12'h100) begin errors++; $display("FAIL mute_dout got %h want 100", bus.dout); end
    step();
  endtask
`endif

  initial begin
    bus.sample_tick = 1'b0;
    bus.voice_in    = '0;
`ifdef VOICE_MIX_MUTE_EN
    bus.mute_mask   = '0;
`endif
    test_reset();
    test_basic();
    test_extremes();
    test_overrun();
    test_snapshot();
    test_reset_midmix();
`ifdef VOICE_MIX_MUTE_EN
    test_mute();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout reached without completing");
    $fatal(1, "timeout");
  end

endmodule
